// File: rtl/ysyx_22050078_pipe_ctrl_pkg.sv
// Shared types for the five-stage pipeline sequencing controller.
// Stage vectors are ordered [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB.
package ysyx_22050078_pipe_ctrl_pkg;

  localparam logic [1:0] PCTL_BOOT     = 2'd0;
  localparam logic [1:0] PCTL_RUN      = 2'd1;
  localparam logic [1:0] PCTL_MEM_WAIT = 2'd2;
  localparam logic [1:0] PCTL_MDU_WAIT = 2'd3;

  typedef enum logic [1:0] {
    ST_BOOT     = PCTL_BOOT,
    ST_RUN      = PCTL_RUN,
    ST_MEM_WAIT = PCTL_MEM_WAIT,
    ST_MDU_WAIT = PCTL_MDU_WAIT
  } pctl_state_e;

  typedef struct packed {
    logic       pcwen;
    logic [3:0] wen;
    logic [3:0] bubble;
  } stage_ctrl_t;

  // A stage register that loads a NOP must never also advance.
  function automatic stage_ctrl_t mk_ctrl(input logic pcwen, input logic [3:0] wen,
                                          input logic [3:0] bubble);
    stage_ctrl_t c;
    c.pcwen  = pcwen;
    c.bubble = bubble;
    c.wen    = wen & ~bubble;
    return c;
  endfunction

endpackage

// File: rtl/ysyx_22050078_lu_detect.sv
// Load-use hazard comparator: ID reads a register that the load in EX is about to write.
module ysyx_22050078_lu_detect (
  input  logic       rs1en,
  input  logic       rs2en,
  input  logic [4:0] rs1idx,
  input  logic [4:0] rs2idx,
  input  logic       memrd,
  input  logic [4:0] rdidx,
  output logic       load_use
);

  // x0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = memrd && (rdidx != 5'd0) &&
                    ((rs1en && (rs1idx == rdidx)) || (rs2en && (rs2idx == rdidx)));

endmodule

// File: rtl/ysyx_22050078_pipe_ctrl.sv
// Pipeline sequencing controller: stage advance/bubble, PC enable, LSU/MDU
// start handshakes, redirect fetch discard and cycle/stall counters.
//
// state    | meaning
// BOOT     | first cycle out of reset, whole pipe bubbled
// RUN      | normal flow, may launch an LSU or MDU op
// MEM_WAIT | LSU access outstanding, waiting for i_lsu_done
// MDU_WAIT | mul/div outstanding, waiting for i_mdu_done
module ysyx_22050078_pipe_ctrl #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_ifu_valid,
  input  logic             i_jump,
  input  logic             i_id_rs1en,
  input  logic             i_id_rs2en,
  input  logic [4:0]       i_id_rs1idx,
  input  logic [4:0]       i_id_rs2idx,
  input  logic             i_ex_memrd,
  input  logic [4:0]       i_ex_rdidx,
  input  logic             i_mdu_req,
  input  logic             i_mdu_done,
  input  logic             i_lsu_req,
  input  logic             i_lsu_done,
  output logic             o_pcwen,
  output logic             o_if2id_wen,
  output logic             o_id2ex_wen,
  output logic             o_ex2mem_wen,
  output logic             o_mem2wb_wen,
  output logic             o_if2id_bubble,
  output logic             o_id2ex_bubble,
  output logic             o_ex2mem_bubble,
  output logic             o_mem2wb_bubble,
  output logic             o_lsu_start,
  output logic             o_mdu_start,
  output logic [CNT_W-1:0] o_cyc_cnt,
  output logic [CNT_W-1:0] o_stall_cnt
);

  import ysyx_22050078_pipe_ctrl_pkg::*;

  pctl_state_e state, state_nxt;
  logic        drop, drop_nxt;
  logic        load_use, stall_mem, stall_ex;
  stage_ctrl_t ctrl;

  ysyx_22050078_lu_detect u_lu_detect (
    .rs1en   (i_id_rs1en),
    .rs2en   (i_id_rs2en),
    .rs1idx  (i_id_rs1idx),
    .rs2idx  (i_id_rs2idx),
    .memrd   (i_ex_memrd),
    .rdidx   (i_ex_rdidx),
    .load_use(load_use)
  );

  always_comb begin
    stall_mem   = ((state == ST_RUN) && i_lsu_req) || ((state == ST_MEM_WAIT) && !i_lsu_done);
    stall_ex    = i_mdu_req && !((state == ST_MDU_WAIT) && i_mdu_done);
    ctrl        = mk_ctrl(1'b0, 4'b0000, 4'b1111);
    state_nxt   = state;
    drop_nxt    = drop;
    o_lsu_start = 1'b0;
    o_mdu_start = 1'b0;

    if (state != ST_BOOT) begin
      if (stall_mem)
        ctrl = mk_ctrl(1'b0, 4'b0000, 4'b0001);
      else if (stall_ex)
        ctrl = mk_ctrl(1'b0, 4'b0001, 4'b0010);
      else if (load_use)
        ctrl = mk_ctrl(1'b0, 4'b0111, 4'b0100);
      else if (i_jump) begin
        // The fetch for the old PC is still outstanding unless it returned now.
        ctrl     = mk_ctrl(1'b1, 4'b0111, 4'b1000);
        drop_nxt = !i_ifu_valid;
      end else if (!i_ifu_valid || drop) begin
        ctrl = mk_ctrl(1'b0, 4'b0111, 4'b1000);
        if (drop && i_ifu_valid)
          drop_nxt = 1'b0;
      end else
        ctrl = mk_ctrl(1'b1, 4'b1111, 4'b0000);
    end

    case (state)
      ST_BOOT: state_nxt = ST_RUN;
      ST_RUN: begin
        if (i_lsu_req) begin
          state_nxt   = ST_MEM_WAIT;
          o_lsu_start = 1'b1;
        end else if (i_mdu_req) begin
          state_nxt   = ST_MDU_WAIT;
          o_mdu_start = 1'b1;
        end
      end
      ST_MEM_WAIT: if (i_lsu_done) state_nxt = ST_RUN;
      ST_MDU_WAIT: if (i_mdu_done) state_nxt = ST_RUN;
      default:     state_nxt = ST_BOOT;
    endcase

    if (rst) begin
      ctrl        = mk_ctrl(1'b0, 4'b0000, 4'b1111);
      o_lsu_start = 1'b0;
      o_mdu_start = 1'b0;
    end
  end

  assign o_pcwen         = ctrl.pcwen;
  assign o_if2id_wen     = ctrl.wen[3];
  assign o_id2ex_wen     = ctrl.wen[2];
  assign o_ex2mem_wen    = ctrl.wen[1];
  assign o_mem2wb_wen    = ctrl.wen[0];
  assign o_if2id_bubble  = ctrl.bubble[3];
  assign o_id2ex_bubble  = ctrl.bubble[2];
  assign o_ex2mem_bubble = ctrl.bubble[1];
  assign o_mem2wb_bubble = ctrl.bubble[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      drop        <= 1'b0;
      o_cyc_cnt   <= '0;
      o_stall_cnt <= '0;
    end else begin
      state <= state_nxt;
      drop  <= drop_nxt;
      if (state != ST_BOOT) begin
        o_cyc_cnt <= o_cyc_cnt + CNT_W'(1);
        if (!ctrl.pcwen)
          o_stall_cnt <= o_stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule
